// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks pc through instruction memory into a DEPTH-entry buffer for the CPU.
// Define IFETCH_HALT_DETECT_EN to stop fetching after a word with opcode [15:12] = 4'hF.
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic        flush,
  input  logic [7:0]  flush_addr,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [15:0] instr,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, STOP} state_t;

  state_t          state;
  logic [7:0]      pc;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            halt_word;

  // A flush cycle swallows both the memory response and any downstream accept.
  assign push = (state == FETCH) && imem_ready && !flush;
  assign pop  = instr_valid && instr_ready && !flush;

`ifdef IFETCH_HALT_DETECT_EN
  assign halt_word = push && (imem_rdata[15:12] == 4'hF);
  assign halted    = (state == STOP);
`else
  assign halt_word = 1'b0;
  assign halted    = 1'b0;
`endif

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem[rd_ptr] : 16'h0000;
  assign busy        = (state == FETCH) || (state == FULL) || (count != '0);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= imem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= 8'h00;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      state  <= FETCH;
      pc     <= flush_addr;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE, STOP: begin
          if (start) begin
            state <= FETCH;
            pc    <= start_addr;
          end
        end
        FETCH: begin
          if (push) begin
            pc <= pc + 8'd1;
            if (halt_word)
              state <= STOP;
            else if (count_next == CW'(DEPTH))
              state <= FULL;
          end
        end
        FULL: begin
          if (count_next < CW'(DEPTH))
            state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed sequences queue expected words, a monitor checks every pop.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic        flush = 1'b0;
  logic [7:0]  flush_addr = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        halted;

  int pass_cnt = 0;
  int total_cnt = 0;
  int acc_cnt = 0;
  logic [15:0] exp_q [$];

  instr_fetch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .flush(flush), .flush_addr(flush_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (a == 8'h80) return 16'h1234;
    if (a == 8'h81) return 16'hF000;
    return {8'h5A, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk)
    if (!rst && imem_req && imem_ready && !flush) acc_cnt++;

  // Monitor: every accepted instruction must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected got=%h required=<none>", instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (instr === e) begin
          pass_cnt++;
          $display("pop instr=%h ok", instr);
        end else
          $display("FAIL pop_data got=%h required=%h", instr, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
      $display("check %s = %0h ok", name, act);
    end else
      $display("FAIL %s got=%0h required=%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; imem_ready = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] a, input logic rdy, input logic irdy);
    start = 1'b1; start_addr = a; imem_ready = rdy; instr_ready = irdy; acc_cnt = 0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    do_reset();

    // streaming from 0x10, first instr two cycles after start
    exp_q.push_back(mem_word(8'h10)); exp_q.push_back(mem_word(8'h11)); exp_q.push_back(mem_word(8'h12));
    start_at(8'h10, 1'b1, 1'b1);
    @(negedge clk); chk("s_n_req", imem_req, 0); chk("s_n_valid", instr_valid, 0);
    tick(); start = 1'b0;
    @(negedge clk); chk("s_n1_addr", imem_addr, 8'h10); chk("s_n1_req", imem_req, 1); chk("s_n1_valid", instr_valid, 0);
    tick(); @(negedge clk); chk("s_n2_addr", imem_addr, 8'h11); chk("s_n2_valid", instr_valid, 1);
    tick(); @(negedge clk); chk("s_n3_addr", imem_addr, 8'h12);
    tick(); imem_ready = 1'b0;
    @(negedge clk); chk("stall_addr0", imem_addr, 8'h13); chk("stall_req0", imem_req, 1);
    tick(); @(negedge clk); chk("stall_addr1", imem_addr, 8'h13); chk("stall_req1", imem_req, 1);
    chk("s_drained", instr_valid, 0); chk("s_busy", busy, 1); chk("s_q_empty", exp_q.size(), 0);
    do_reset();

    // fill to FULL, one pop reopens fetch at start+4
    for (int i = 0; i < 5; i++) exp_q.push_back(mem_word(8'h20 + 8'(i)));
    start_at(8'h20, 1'b1, 1'b0);
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk); chk("full_req0", imem_req, 0); chk("full_addr", imem_addr, 8'h24); chk("full_valid", instr_valid, 1);
    tick(); @(negedge clk); chk("full_req1", imem_req, 0); chk("full_acc", acc_cnt, 4);
    tick(); instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;
    @(negedge clk); chk("refetch_req", imem_req, 1); chk("refetch_addr", imem_addr, 8'h24);
    tick(); imem_ready = 1'b0; instr_ready = 1'b1;
    @(negedge clk); chk("refull_req", imem_req, 0); chk("refull_acc", acc_cnt, 5);
    for (int i = 0; i < 6; i++) tick();
    chk("full_q_empty", exp_q.size(), 0); chk("full_drained", instr_valid, 0);
    do_reset();

    // pc wrap 0xFE -> 0x00
    exp_q.push_back(mem_word(8'hFE)); exp_q.push_back(mem_word(8'hFF)); exp_q.push_back(mem_word(8'h00));
    start_at(8'hFE, 1'b1, 1'b1);
    tick(); start = 1'b0;
    @(negedge clk); chk("wrap_a0", imem_addr, 8'hFE);
    tick(); @(negedge clk); chk("wrap_a1", imem_addr, 8'hFF);
    tick(); @(negedge clk); chk("wrap_a2", imem_addr, 8'h00);
    tick(); imem_ready = 1'b0;
    tick(); tick(); tick();
    chk("wrap_q_empty", exp_q.size(), 0);
    do_reset();

    // flush coinciding with a memory response
    start_at(8'h30, 1'b1, 1'b0);
    tick(); start = 1'b0;
    tick();
    tick(); flush = 1'b1; flush_addr = 8'h40;
    tick(); flush = 1'b0; instr_ready = 1'b1;
    exp_q.push_back(mem_word(8'h40));
    @(negedge clk); chk("flush_valid", instr_valid, 0); chk("flush_addr", imem_addr, 8'h40); chk("flush_req", imem_req, 1);
    tick(); imem_ready = 1'b0;
    tick(); tick();
    chk("flush_q_empty", exp_q.size(), 0); chk("flush_drained", instr_valid, 0);
    do_reset();

    // HALT opcode
    exp_q.push_back(16'h1234); exp_q.push_back(16'hF000);
`ifndef IFETCH_HALT_DETECT_EN
    exp_q.push_back(mem_word(8'h82));
`endif
    start_at(8'h80, 1'b1, 1'b1);
    tick(); start = 1'b0;
    tick(); tick();
    @(negedge clk);
`ifdef IFETCH_HALT_DETECT_EN
    chk("halt_req", imem_req, 0); chk("halt_flag", halted, 1);
`else
    chk("nohalt_req", imem_req, 1); chk("nohalt_flag", halted, 0);
`endif
    tick(); imem_ready = 1'b0;
    tick(); tick(); tick();
`ifdef IFETCH_HALT_DETECT_EN
    chk("halt_acc", acc_cnt, 2); chk("halt_flag2", halted, 1); chk("halt_busy", busy, 0);
`else
    chk("nohalt_acc", acc_cnt, 3); chk("nohalt_busy", busy, 1);
`endif
    chk("halt_q_empty", exp_q.size(), 0);
    do_reset();

    // asynchronous reset mid-request with two buffered words
    start_at(8'h50, 1'b1, 1'b0);
    tick(); start = 1'b0;
    tick(); tick(); imem_ready = 1'b0;
    chk("pre_rst_req", imem_req, 1); chk("pre_rst_valid", instr_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0); chk("arst_addr", imem_addr, 8'h00); chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 16'h0000); chk("arst_busy", busy, 0); chk("arst_halted", halted, 0);
    tick(); rst = 1'b0;
    tick(); tick();
    @(negedge clk); chk("post_rst_req", imem_req, 0); chk("post_rst_busy", busy, 0);
    tick(); start_at(8'h60, 1'b0, 1'b0);
    tick(); start = 1'b0;
    @(negedge clk); chk("resume_req", imem_req, 1); chk("resume_addr", imem_addr, 8'h60);
    chk("end_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
